// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM encoding,
// parity modes and the counter width helper.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REQ    = 3'd1,
      ST_LOAD   = 3'd2,
      ST_START  = 3'd3,
      ST_DATA   = 3'd4,
      ST_PARITY = 3'd5,
      ST_STOP   = 3'd6
   } uart_state_t;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   // clog2 with a floor of one bit, so degenerate ranges still get a real register
   function automatic int width_of(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read port of the synchronous TX FIFO as seen by the UART drain.
// master = UART transmitter side, slave = FIFO side.
interface fifo_uart_tx_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  fifo_rd_en;
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_dout;

   modport master (
      output fifo_rd_en,
      input  fifo_empty,
      input  fifo_dout
   );

   modport slave (
      input  fifo_rd_en,
      output fifo_empty,
      output fifo_dout
   );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-time counter: counts 0..CLK_DIV-1 while run is high and flags the
// last cycle of each bit with a one-cycle tick.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int CLK_DIV = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic tick
);

   localparam int              CW   = width_of(CLK_DIV);
   localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (!run || cnt_q == LAST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops one byte per frame from the TX FIFO and serializes it on txd as an
// async UART frame (start, LSB-first data, optional parity, stop bits).
//
// state  | meaning
// IDLE   | line high, waiting for tx_en and a non-empty FIFO
// REQ    | one-cycle pop request on fifo_rd_en
// LOAD   | FIFO data valid; capture byte and parity
// START  | start bit (low), one bit time
// DATA   | data bits, LSB first, one bit time each
// PARITY | parity bit, only when PARITY != none
// STOP   | STOP_BITS bit times high; frame_done on the last cycle
module fifo_uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CLK_DIV    = 16,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            tx_en,
   fifo_uart_tx_if.master  fifo,
   output logic            txd,
   output logic            busy,
   output logic            frame_done
);

   localparam int            BW        = width_of(DATA_WIDTH + 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

   uart_state_t           state_q, state_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic                  par_q, par_d;
   logic                  rd_en_q, rd_en_d;
   logic                  txd_q, txd_d;
   logic                  run;
   logic                  tick;

   uart_baud_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_baud (
      .clk   (clk),
      .rst_n (rst_n),
      .run   (run),
      .tick  (tick)
   );

   assign run = (state_q == ST_START) || (state_q == ST_DATA) ||
                (state_q == ST_PARITY) || (state_q == ST_STOP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         shreg_q <= '0;
         bit_q   <= '0;
         par_q   <= 1'b0;
         rd_en_q <= 1'b0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         bit_q   <= bit_d;
         par_q   <= par_d;
         rd_en_q <= rd_en_d;
         txd_q   <= txd_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      bit_d      = bit_q;
      par_d      = par_q;
      rd_en_d    = 1'b0;
      frame_done = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // empty is only looked at here, long after the previous pop
            if (tx_en && !fifo.fifo_empty) begin
               state_d = ST_REQ;
               rd_en_d = 1'b1;
            end
         end
         ST_REQ: begin
            state_d = ST_LOAD;
         end
         ST_LOAD: begin
            shreg_d = fifo.fifo_dout;
            par_d   = (PARITY == PARITY_ODD) ? ~(^fifo.fifo_dout) : ^fifo.fifo_dout;
            bit_d   = '0;
            state_d = ST_START;
         end
         ST_START: begin
            if (tick) begin
               bit_d   = '0;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (tick) begin
               shreg_d = shreg_q >> 1;
               if (bit_q == DATA_LAST) begin
                  bit_d   = '0;
                  state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         ST_PARITY: begin
            if (tick) begin
               bit_d   = '0;
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (tick) begin
               if (bit_q == STOP_LAST) begin
                  frame_done = 1'b1;
                  state_d    = ST_IDLE;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // txd is registered from the next state so the pin never sees decode glitches
      case (state_d)
         ST_START:  txd_d = 1'b0;
         ST_DATA:   txd_d = shreg_d[0];
         ST_PARITY: txd_d = par_q;
         default:   txd_d = 1'b1;
      endcase
   end

   assign txd             = txd_q;
   assign busy            = (state_q != ST_IDLE);
   assign fifo.fifo_rd_en = rd_en_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: three transmitters (PARITY 0/1/2, CLK_DIV=4) each fed by
// a behavioural FIFO with a registered empty flag.
module tb_fifo_uart_tx;

   localparam int CD = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] tx_en;
   logic [2:0] txd;
   logic [2:0] busy;
   logic [2:0] frame_done;

   logic [7:0] fq [3][$];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : ch
      fifo_uart_tx_if #(.DATA_WIDTH(8)) fif ();
      int pops = 0;

      always @(posedge clk) begin
         if (fif.fifo_rd_en) begin
            pops++;
            if (fq[g].size() > 0) fif.fifo_dout <= fq[g].pop_front();
         end
         fif.fifo_empty <= (fq[g].size() == 0);
      end

      fifo_uart_tx #(
         .DATA_WIDTH (8),
         .CLK_DIV    (CD),
         .PARITY     (g),
         .STOP_BITS  (1)
      ) dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .tx_en      (tx_en[g]),
         .fifo       (fif.master),
         .txd        (txd[g]),
         .busy       (busy[g]),
         .frame_done (frame_done[g])
      );
   end

   task automatic wait_txd_low(input int idx, input int max_c, output int waited);
      waited = 0;
      while (txd[idx] !== 1'b0 && waited < max_c) begin
         @(negedge clk);
         waited++;
      end
   endtask

   // Samples a frame starting at the current negedge (first start-bit cycle).
   task automatic get_frame(input int idx, input int nbits, input int drop_at,
                            output logic [15:0] bits, output bit stable,
                            output int fd_pos, output int fd_n);
      logic v;
      bits   = '1;
      stable = 1'b1;
      fd_pos = 0;
      fd_n   = 0;
      for (int b = 0; b < nbits; b++) begin
         for (int c = 0; c < CD; c++) begin
            if (b * CD + c + 1 == drop_at) tx_en[idx] = 1'b0;
            v = txd[idx];
            if (c == 0) bits[b] = v;
            else if (v !== bits[b]) stable = 1'b0;
            if (frame_done[idx] === 1'b1) begin
               fd_n++;
               fd_pos = b * CD + c + 1;
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_reset();
      logic [2:0] acc;
      rst_n = 1'b0;
      tx_en = 3'b111;
      repeat (3) @(negedge clk);
      total++; if (txd !== 3'b111) begin bad++; $display("FAIL reset_txd: got %b want 111", txd); end
      total++; if (busy !== 3'b000) begin bad++; $display("FAIL reset_busy: got %b want 000", busy); end
      total++; if (frame_done !== 3'b000) begin bad++; $display("FAIL reset_frame_done: got %b want 000", frame_done); end
      rst_n = 1'b1;
      acc = 3'b111;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         acc = acc & txd;
      end
      total++; if (acc !== 3'b111) begin bad++; $display("FAIL idle_txd_high: got %b want 111", acc); end
      total++; if (busy !== 3'b000) begin bad++; $display("FAIL idle_busy: got %b want 000", busy); end
      total++; if (ch[0].pops + ch[1].pops + ch[2].pops !== 0) begin
         bad++; $display("FAIL idle_no_pop: got %0d want 0", ch[0].pops + ch[1].pops + ch[2].pops);
      end
   endtask

   task automatic test_single();
      int w, fdp, fdn, p;
      logic [15:0] bits;
      bit st;
      p = ch[0].pops;
      fq[0].push_back(8'hA5);
      @(negedge clk);
      total++; if (ch[0].fif.fifo_empty !== 1'b0) begin bad++; $display("FAIL single_empty_low: got %b want 0", ch[0].fif.fifo_empty); end
      wait_txd_low(0, 20, w);
      total++; if (w !== 3) begin bad++; $display("FAIL single_latency: got %0d want 3", w); end
      get_frame(0, 10, -1, bits, st, fdp, fdn);
      total++; if (bits[9:0] !== 10'b1101001010) begin bad++; $display("FAIL single_bits: got %b want 1101001010", bits[9:0]); end
      total++; if (st !== 1'b1) begin bad++; $display("FAIL single_bit_width: got %b want 1", st); end
      total++; if (fdp !== 40 || fdn !== 1) begin bad++; $display("FAIL single_frame_done: got pos %0d count %0d want pos 40 count 1", fdp, fdn); end
      total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL single_busy_after: got %b want 0", busy[0]); end
      total++; if (ch[0].pops - p !== 1) begin bad++; $display("FAIL single_pops: got %0d want 1", ch[0].pops - p); end
   endtask

   task automatic test_parity();
      int w, fdp, fdn;
      logic [15:0] bits;
      logic [10:0] exp;
      bit st;
      for (int k = 1; k <= 2; k++) begin
         exp = (k == 1) ? 11'b11000001110 : 11'b10000001110;
         fq[k].push_back(8'h07);
         @(negedge clk);
         wait_txd_low(k, 20, w);
         total++; if (w !== 3) begin bad++; $display("FAIL parity%0d_latency: got %0d want 3", k, w); end
         get_frame(k, 11, -1, bits, st, fdp, fdn);
         total++; if (bits[10:0] !== exp) begin bad++; $display("FAIL parity%0d_bits: got %b want %b", k, bits[10:0], exp); end
         total++; if (st !== 1'b1) begin bad++; $display("FAIL parity%0d_bit_width: got %b want 1", k, st); end
         total++; if (fdp !== 44 || fdn !== 1) begin bad++; $display("FAIL parity%0d_frame_done: got pos %0d count %0d want pos 44 count 1", k, fdp, fdn); end
      end
   endtask

   task automatic test_back_to_back();
      int w, fdp, fdn, p;
      logic [15:0] bits;
      bit st;
      p = ch[0].pops;
      fq[0].push_back(8'h01);
      fq[0].push_back(8'h02);
      fq[0].push_back(8'h03);
      @(negedge clk);
      wait_txd_low(0, 20, w);
      total++; if (w !== 3) begin bad++; $display("FAIL b2b_first_latency: got %0d want 3", w); end
      for (int k = 0; k < 3; k++) begin
         get_frame(0, 10, -1, bits, st, fdp, fdn);
         total++; if (bits[8:1] !== 8'(k + 1)) begin bad++; $display("FAIL b2b_byte%0d: got %h want %h", k, bits[8:1], k + 1); end
         total++; if (bits[0] !== 1'b0 || bits[9] !== 1'b1 || st !== 1'b1) begin
            bad++; $display("FAIL b2b_frame%0d_format: got start %b stop %b stable %b want 0 1 1", k, bits[0], bits[9], st);
         end
         if (k < 2) begin
            wait_txd_low(0, 20, w);
            total++; if (w !== 3) begin bad++; $display("FAIL b2b_gap%0d: got %0d idle cycles want 3", k, w); end
         end
      end
      repeat (20) @(negedge clk);
      total++; if (ch[0].pops - p !== 3) begin bad++; $display("FAIL b2b_pops: got %0d want 3", ch[0].pops - p); end
      total++; if (ch[0].fif.fifo_empty !== 1'b1) begin bad++; $display("FAIL b2b_empty_end: got %b want 1", ch[0].fif.fifo_empty); end
      total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL b2b_busy_end: got %b want 0", busy[0]); end
   endtask

   task automatic test_tx_en_gating();
      int w, fdp, fdn, p;
      logic [15:0] bits;
      bit st, quiet;
      p = ch[0].pops;
      fq[0].push_back(8'h5A);
      fq[0].push_back(8'hC3);
      @(negedge clk);
      wait_txd_low(0, 20, w);
      total++; if (w !== 3) begin bad++; $display("FAIL gate_latency: got %0d want 3", w); end
      get_frame(0, 10, 12, bits, st, fdp, fdn);
      total++; if (bits[8:1] !== 8'h5A || bits[9] !== 1'b1) begin bad++; $display("FAIL gate_byte1: got %h stop %b want 5a stop 1", bits[8:1], bits[9]); end
      total++; if (fdp !== 40) begin bad++; $display("FAIL gate_byte1_done: got %0d want 40", fdp); end
      quiet = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (txd[0] !== 1'b1 || busy[0] !== 1'b0) quiet = 1'b0;
         @(negedge clk);
      end
      total++; if (quiet !== 1'b1) begin bad++; $display("FAIL gate_held_idle: got %b want 1", quiet); end
      total++; if (ch[0].pops - p !== 1) begin bad++; $display("FAIL gate_no_req: got %0d pops want 1", ch[0].pops - p); end
      tx_en[0] = 1'b1;
      wait_txd_low(0, 20, w);
      total++; if (w !== 3) begin bad++; $display("FAIL gate_resume_latency: got %0d want 3", w); end
      get_frame(0, 10, -1, bits, st, fdp, fdn);
      total++; if (bits[8:1] !== 8'hC3 || st !== 1'b1) begin bad++; $display("FAIL gate_byte2: got %h stable %b want c3 1", bits[8:1], st); end
      total++; if (ch[0].pops - p !== 2) begin bad++; $display("FAIL gate_pops: got %0d want 2", ch[0].pops - p); end
   endtask

   task automatic test_reset_mid_frame();
      int w, fdp, fdn, p;
      logic [15:0] bits;
      bit st;
      p = ch[0].pops;
      fq[0].push_back(8'h00);
      fq[0].push_back(8'h3C);
      @(negedge clk);
      wait_txd_low(0, 20, w);
      total++; if (w !== 3) begin bad++; $display("FAIL rstmid_latency: got %0d want 3", w); end
      repeat (17) @(negedge clk);
      total++; if (txd[0] !== 1'b0) begin bad++; $display("FAIL rstmid_data_low: got %b want 0", txd[0]); end
      rst_n = 1'b0;
      #1;
      total++; if (txd[0] !== 1'b1) begin bad++; $display("FAIL rstmid_txd_async: got %b want 1", txd[0]); end
      total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy[0]); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_txd_low(0, 30, w);
      total++; if (w !== 3) begin bad++; $display("FAIL rstmid_restart_latency: got %0d want 3", w); end
      get_frame(0, 10, -1, bits, st, fdp, fdn);
      total++; if (bits[8:1] !== 8'h3C || bits[0] !== 1'b0 || bits[9] !== 1'b1 || st !== 1'b1) begin
         bad++; $display("FAIL rstmid_next_byte: got %h start %b stop %b stable %b want 3c 0 1 1", bits[8:1], bits[0], bits[9], st);
      end
      total++; if (ch[0].pops - p !== 2) begin bad++; $display("FAIL rstmid_pops: got %0d want 2", ch[0].pops - p); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_parity();
      test_back_to_back();
      test_tx_en_gating();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      repeat (50000) @(posedge clk);
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
